// File: rtl/key_debounce_pkg.sv
// Shared types and sizing helpers for the KEY[3:0] debounce/edge block.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    KD_UP,
    KD_WAIT_DN,
    KD_DOWN,
    KD_WAIT_UP
  } kd_state_t;

  // Bits needed to hold 0..n-1; never less than one bit.
  function automatic int kd_cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  function automatic int kd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: 2-FF synchroniser, stable-time debounce FSM, registered press/release strobes.
// KEY_DEBOUNCE_AUTOREPEAT_EN adds a repeat counter that re-fires press_pulse while held.
module key_debounce_channel
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = 500_000
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
 ,parameter int REPEAT_DELAY_CYCLES  = 25_000_000
 ,parameter int REPEAT_PERIOD_CYCLES = 5_000_000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_raw,
  output logic key_n_db,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = kd_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  kd_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            db_q, db_d;
  logic            pressed_q, pressed_d;
  logic            press_q, press_d;
  logic            release_q, release_d;

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam int RPT_W = kd_cnt_width(kd_max(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES));
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD_CYCLES - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  // Set until the first repeat has fired; selects delay vs. period as the target.
  logic             rpt_first_q, rpt_first_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= KD_UP;
      cnt_q     <= '0;
      db_q      <= 1'b1;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= key_n_raw;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    db_d      = db_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
`endif

    case (state_q)
      KD_UP: begin
        if (!sync2_q) begin
          state_d = KD_WAIT_DN;
          cnt_d   = CNT_W'(1);
        end
      end

      KD_WAIT_DN: begin
        if (sync2_q) begin
          state_d = KD_UP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = KD_DOWN;
          cnt_d   = '0;
          db_d    = 1'b0;
          press_d = 1'b1;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
          rpt_d       = '0;
          rpt_first_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      KD_DOWN: begin
        if (sync2_q) begin
          state_d = KD_WAIT_UP;
          cnt_d   = CNT_W'(1);
        end
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        else if (rpt_q == (rpt_first_q ? RPT_FIRST : RPT_NEXT)) begin
          press_d     = 1'b1;
          rpt_d       = '0;
          rpt_first_d = 1'b0;
        end else begin
          rpt_d = rpt_q + RPT_W'(1);
        end
`endif
      end

      KD_WAIT_UP: begin
        if (!sync2_q) begin
          state_d = KD_DOWN;
          cnt_d   = '0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
          rpt_d       = '0;
          rpt_first_d = 1'b1;
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_d   = KD_UP;
          cnt_d     = '0;
          db_d      = 1'b1;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = KD_UP;
        cnt_d   = '0;
      end
    endcase

    pressed_d = ~db_d;
  end

  assign key_n_db      = db_q;
  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/key_debounce_edge.sv
// Debounces the active-low DE2-115 KEY buttons: one independent channel per key.
// Define KEY_DEBOUNCE_AUTOREPEAT_EN to enable held-key auto-repeat press pulses.
module key_debounce_edge
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS             = 4,
  parameter int DEBOUNCE_CYCLES      = 500_000,
  parameter int REPEAT_DELAY_CYCLES  = 25_000_000,
  parameter int REPEAT_PERIOD_CYCLES = 5_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n_raw,
  output logic [NUM_KEYS-1:0] key_n_db,
  output logic [NUM_KEYS-1:0] pressed,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_debounce_edge: DEBOUNCE_CYCLES must be >= 2");
  end

  if (REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_bad_repeat
    $error("key_debounce_edge: REPEAT_* cycle counts must be >= 1");
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES)
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
     ,.REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES)
     ,.REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
`endif
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .key_n_raw     (key_n_raw[k]),
      .key_n_db      (key_n_db[k]),
      .pressed       (pressed[k]),
      .press_pulse   (press_pulse[k]),
      .release_pulse (release_pulse[k])
    );
  end

endmodule

// File: tb/tb_key_debounce_edge.sv
// Directed bench for key_debounce_edge with DEBOUNCE_CYCLES=8 (press/release land on edge 10).
// The repeat scenario's expectations follow KEY_DEBOUNCE_AUTOREPEAT_EN.
module tb_key_debounce_edge;

  localparam int NK = 4;

  logic          clk;
  logic          reset;
  logic [NK-1:0] key_n_raw;
  logic [NK-1:0] key_n_db;
  logic [NK-1:0] pressed;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;

  int n_chk;
  int n_fail;

  key_debounce_edge #(
    .NUM_KEYS             (NK),
    .DEBOUNCE_CYCLES      (8),
    .REPEAT_DELAY_CYCLES  (20),
    .REPEAT_PERIOD_CYCLES (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_n_raw     (key_n_raw),
    .key_n_db      (key_n_db),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset     = 1'b1;
    key_n_raw = 4'b0000;

    // 1: reset held with every key pressed
    #1;
    for (int e = 0; e < 5; e++) begin
      tick();
      chk("t1_db", 32'(key_n_db), 32'hF);
      chk("t1_outs", 32'({pressed, press_pulse, release_pulse}), 32'h0);
    end
    key_n_raw = 4'b1111;
    tick();
    tick();
    reset = 1'b0;
    for (int e = 0; e < 3; e++) tick();
    chk("t1_after_rel", 32'({key_n_db, pressed}), 32'hF0);

    // 2: key0 falls cleanly
    key_n_raw[0] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk("t2_db0", 32'(key_n_db[0]), (e >= 10) ? 32'd0 : 32'd1);
      chk("t2_pressed0", 32'(pressed[0]), (e >= 10) ? 32'd1 : 32'd0);
      chk("t2_pp0", 32'(press_pulse[0]), (e == 10) ? 32'd1 : 32'd0);
    end

    // 3: key1 bounces (low 3, high 2, low 3, high) and never settles long enough
    for (int i = 0; i < 20; i++) begin
      key_n_raw[1] = (i < 3) ? 1'b0 : (i < 5) ? 1'b1 : (i < 8) ? 1'b0 : 1'b1;
      tick();
      chk("t3_db1", 32'(key_n_db[1]), 32'd1);
      chk("t3_pulses1", 32'({press_pulse[1], release_pulse[1]}), 32'd0);
    end

    // 4: key0 released cleanly
    key_n_raw[0] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk("t4_db0", 32'(key_n_db[0]), (e >= 10) ? 32'd1 : 32'd0);
      chk("t4_rp0", 32'(release_pulse[0]), (e == 10) ? 32'd1 : 32'd0);
    end

    // 5: keys 2,3 fall together; key3 is high during cycle 4 only, so its
    // WAIT_DN aborts at edge 6, restarts at edge 7 and completes at edge 14
    key_n_raw[3:2] = 2'b00;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 3) key_n_raw[3] = 1'b1;
      if (e == 4) key_n_raw[3] = 1'b0;
      chk("t5_db2", 32'(key_n_db[2]), (e >= 10) ? 32'd0 : 32'd1);
      chk("t5_pp2", 32'(press_pulse[2]), (e == 10) ? 32'd1 : 32'd0);
      chk("t5_db3", 32'(key_n_db[3]), (e >= 14) ? 32'd0 : 32'd1);
      chk("t5_pp3", 32'(press_pulse[3]), (e == 14) ? 32'd1 : 32'd0);
    end

    // 6: reset during key1's WAIT_DN (cnt=5 after edge 7)
    key_n_raw[1] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk("t6_pre_pp1", 32'(press_pulse[1]), 32'd0);
    end
    reset = 1'b1;
    #1;
    chk("t6_rst_db", 32'(key_n_db), 32'hF);
    chk("t6_rst_outs", 32'({pressed, press_pulse, release_pulse}), 32'h0);
    tick();
    tick();
    chk("t6_rst_pp", 32'(press_pulse), 32'h0);
    reset = 1'b0;
    // keys 1,2,3 remain held and come back as fresh presses
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk("t6_db", 32'(key_n_db), (e >= 10) ? 32'h1 : 32'hF);
      chk("t6_pp", 32'(press_pulse), (e == 10) ? 32'hE : 32'h0);
    end

    // release everything and let it settle
    key_n_raw = 4'b1111;
    for (int e = 0; e < 14; e++) tick();
    chk("t7_idle_db", 32'(key_n_db), 32'hF);

    // 7: key0 held 45 cycles past debounce; repeats at +20,+25,...,+45 only
    // when auto-repeat is built in
    key_n_raw[0] = 1'b0;
    for (int e = 1; e <= 10; e++) tick();
    chk("t7_pp0_first", 32'(press_pulse[0]), 32'd1);
    for (int k = 1; k <= 45; k++) begin
      logic rep;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
      rep = (k >= 20) && ((k - 20) % 5 == 0);
`else
      rep = 1'b0;
`endif
      tick();
      chk("t7_pp0_hold", 32'(press_pulse[0]), 32'(rep));
      chk("t7_db0_hold", 32'(key_n_db[0]), 32'd0);
    end
    key_n_raw[0] = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick();
      chk("t7_pp0_after", 32'(press_pulse[0]), 32'd0);
      chk("t7_rp0", 32'(release_pulse[0]), (e == 10) ? 32'd1 : 32'd0);
    end
    chk("t7_db_final", 32'(key_n_db), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
